fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_controller.sv | 117 +++++++++++
 tb/tb_fetch_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// FSM states, queue entry layout and address helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } fetch_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, inst} entries.
// Synchronous flush wins over push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC sequencing, redirect handling
// and a prefetch queue fed by a one-cycle-latency instruction memory.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = CW + 1;

  fetch_state_e  state_q;
  logic [31:0]   pc_q, pc_d;
  logic          epoch_q, epoch_d;
  logic          infl_q;
  logic [31:0]   infl_pc_q;
  logic          infl_ep_q;

  logic [CW-1:0] count;
  logic          empty;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          deq;
  logic          push;
  logic          room;
  logic [NW-1:0] need;

  assign deq = inst_valid && inst_ready;

  // A dequeue this cycle frees its slot for this cycle's issue.
  assign need = {1'b0, count} + NW'(infl_q) - NW'(deq);
  assign room = need < NW'(DEPTH);

  assign push = infl_q && (infl_ep_q == epoch_q) && !redirect_valid;
  assign push_data = '{pc: infl_pc_q, inst: imem_rdata};

  always_comb begin
    imem_rd_en = 1'b0;
    unique case (state_q)
      ST_RUN:   imem_rd_en = room && !redirect_valid;
      ST_REDIR: imem_rd_en = !redirect_valid;
      default:  imem_rd_en = 1'b0;
    endcase
  end

  assign imem_addr = pc_q;

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (redirect_valid) begin
      pc_d    = word_align(redirect_pc);
      epoch_d = ~epoch_q;
    end else if (imem_rd_en) begin
      pc_d = pc_q + 32'(WORD_BYTES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      epoch_q   <= 1'b0;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      infl_ep_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      epoch_q   <= epoch_d;
      infl_q    <= imem_rd_en;
      infl_pc_q <= pc_q;
      infl_ep_q <= epoch_q;
      if (redirect_valid) begin
        state_q <= ST_REDIR;
      end else begin
        unique case (state_q)
          ST_BOOT:  state_q <= ST_RUN;
          ST_RUN:   state_q <= ST_RUN;
          ST_REDIR: state_q <= ST_RUN;
          default:  state_q <= ST_BOOT;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (deq),
    .head_o     (head),
    .count_o    (count),
    .empty_o    (empty)
  );

  assign inst_valid = !empty;
  assign inst       = empty ? '0 : head.inst;
  assign inst_pc    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus random traffic
// checked against a stream-level reference model.
module tb_fetch_controller;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  fetch_controller #(
    .DEPTH   (DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rd_en    (imem_rd_en),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Reference model: issue times of live requests, next pcs expected.
  int          now;
  int          issq[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_ipc;
  bit          boot;
  logic [31:0] xfers[$];
  logic [31:0] issued[$];

  logic        s_re, s_v;
  logic [31:0] s_a, s_p, s_i;

  bit          trig_en;
  logic [31:0] trig_pc, trig_tgt;

  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit exp_v, exp_re;
    int pend;
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    #1;
    if (trig_en && inst_valid && inst_pc == trig_pc) begin
      redirect_valid = 1'b1;
      redirect_pc    = trig_tgt;
      rv  = 1'b1;
      rpc = trig_tgt;
      trig_en = 1'b0;
      #1;
    end
    s_re = imem_rd_en;
    s_a  = imem_addr;
    s_v  = inst_valid;
    s_p  = inst_pc;
    s_i  = inst;
    exp_v = issq.size() > 0 && issq[0] <= now - 2;
    chk("inst_valid", 32'(s_v), 32'(exp_v));
    if (exp_v && s_v) begin
      chk("inst_pc", s_p, exp_pc);
      chk("inst", s_i, mem_word(exp_pc));
    end
    pend = issq.size() - ((exp_v && rdy) ? 1 : 0);
    exp_re = !boot && !rv && pend < DEPTH;
    chk("rd_en", 32'(s_re), 32'(exp_re));
    if (s_re) begin
      chk("imem_addr", s_a, exp_ipc);
      issued.push_back(s_a);
    end
    if (exp_v && rdy) begin
      xfers.push_back(exp_pc);
      void'(issq.pop_front());
      exp_pc = exp_pc + 32'd4;
    end
    if (exp_re) begin
      issq.push_back(now);
      exp_ipc = exp_ipc + 32'd4;
    end
    if (rv) begin
      issq.delete();
      exp_pc  = {rpc[31:2], 2'b00};
      exp_ipc = exp_pc;
    end
    boot = 1'b0;
    @(posedge clk);
    #1;
    imem_rdata = s_re ? mem_word(s_a) : $urandom;
    now++;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    #1;
    chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_addr", imem_addr, RPC);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    issq.delete();
    exp_pc  = RPC;
    exp_ipc = RPC;
    boot    = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first;
    int          idx;
    logic [31:0] v;
    logic [31:0] e4[5];
    logic [31:0] ew[3];

    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    imem_rdata = '0;
    trig_en = 1'b0;
    now = 0;
    boot = 1'b1;
    exp_pc = RPC;
    exp_ipc = RPC;
    s_re = 1'b0;

    // Streaming with consumer always ready.
    do_reset();
    xfers.delete();
    first = -1;
    for (int c = 1; c <= 12; c++) begin
      cycle(1'b0, '0, 1'b1);
      if (s_re && first < 0) first = c;
    end
    chk("first_issue_cyc", 32'(first), 32'd2);
    chk("stream_count", 32'(xfers.size()), 32'd9);
    for (int k = 0; k < xfers.size(); k++)
      chk("stream_pc", xfers[k], 32'(k * 4));

    // Consumer stalled: queue fills to DEPTH and holds head.
    do_reset();
    issued.delete();
    repeat (10) cycle(1'b0, '0, 1'b0);
    chk("stall_issues", 32'(issued.size()), 32'(DEPTH));
    for (int k = 0; k < issued.size(); k++)
      chk("stall_addr", issued[k], 32'(k * 4));
    xfers.delete();
    cycle(1'b0, '0, 1'b1);
    v = (xfers.size() > 0) ? xfers[0] : 32'hDEAD_BEEF;
    chk("stall_release_head", v, 32'h0);
    repeat (4) cycle(1'b0, '0, 1'b1);

    // Redirect while the request for 0x10 is in flight.
    do_reset();
    s_re = 1'b0;
    for (int k = 0; k < 20 && !(s_re && s_a == 32'h10); k++)
      cycle(1'b0, '0, 1'b1);
    chk("find_req_10", 32'(s_re && s_a == 32'h10), 32'd1);
    cycle(1'b1, 32'h0000_0043, 1'b1);
    xfers.delete();
    cycle(1'b0, '0, 1'b1);
    chk("redir_issue", 32'(s_re), 32'd1);
    chk("redir_addr", s_a, 32'h40);
    repeat (4) cycle(1'b0, '0, 1'b1);
    v = (xfers.size() > 0) ? xfers[0] : 32'hDEAD_BEEF;
    chk("redir_head", v, 32'h40);

    // Redirect in the same cycle as dequeue of 0x8.
    do_reset();
    trig_en  = 1'b1;
    trig_pc  = 32'h8;
    trig_tgt = 32'h100;
    xfers.delete();
    repeat (12) cycle(1'b0, '0, 1'b1);
    chk("trig_fired", 32'(trig_en), 32'd0);
    e4 = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
    for (int k = 0; k < 5; k++) begin
      v = (xfers.size() > k) ? xfers[k] : 32'hDEAD_BEEF;
      chk("deq_redir_seq", v, e4[k]);
    end

    // Redirect near the top of the address space wraps to zero.
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    xfers.delete();
    repeat (8) cycle(1'b0, '0, 1'b1);
    ew = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    for (int k = 0; k < 3; k++) begin
      v = (xfers.size() > k) ? xfers[k] : 32'hDEAD_BEEF;
      chk("wrap_seq", v, ew[k]);
    end

    // Back-to-back redirects: the later target wins.
    cycle(1'b1, 32'h200, 1'b1);
    cycle(1'b1, 32'h300, 1'b1);
    xfers.delete();
    repeat (6) cycle(1'b0, '0, 1'b1);
    v = (xfers.size() > 0) ? xfers[0] : 32'hDEAD_BEEF;
    chk("double_redir", v, 32'h300);

    // Reset with three entries queued and one request in flight.
    do_reset();
    repeat (5) cycle(1'b0, '0, 1'b0);
    chk("pre_rst_valid", 32'(inst_valid), 32'd1);
    chk("pre_rst_inflight", 32'(s_re), 32'd1);
    do_reset();
    issued.delete();
    repeat (6) cycle(1'b0, '0, 1'b1);
    v = (issued.size() > 0) ? issued[0] : 32'hDEAD_BEEF;
    chk("restart_addr", v, RPC);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      idx = $urandom_range(0, 999);
      if (idx < 4) do_reset();
      else cycle(idx < 30, $urandom, $urandom_range(0, 99) < 70);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
